// File: rtl/tile_render_sched_if.sv
// Pixel/board bus between the VGA timing, game logic and the tile render scheduler.
// The master side is the VGA counters plus game logic; the slave side is the scheduler.
interface tile_render_sched_if;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [63:0] board_in;
  logic        upd_req;
  logic        upd_ack;
  logic [4:0]  curpos;
  logic [3:0]  curdata;
  logic [10:0] h_cnt_q;
  logic [10:0] v_cnt_q;
  logic        frame_tick;
  logic [7:0]  frame_cnt;

  modport master (
    output h_cnt, v_cnt, board_in, upd_req,
    input  upd_ack, curpos, curdata, h_cnt_q, v_cnt_q, frame_tick, frame_cnt
  );

  modport slave (
    input  h_cnt, v_cnt, board_in, upd_req,
    output upd_ack, curpos, curdata, h_cnt_q, v_cnt_q, frame_tick, frame_cnt
  );
endinterface

// File: rtl/tile_render_sched.sv
// 2048 tile renderer sequencer: tear-free board shadow committed in vblank,
// per-pixel tile decode (latency 1) and a frame tick/counter for animation.
module tile_render_sched #(
  parameter int unsigned X0       = 136,
  parameter int unsigned Y0       = 66,
  parameter int unsigned TILE     = 80,
  parameter int unsigned PITCH    = 96,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_render_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LATCH, WAIT_DROP} state_t;

  state_t      state;
  logic [63:0] shadow;
  logic        upd_ack_q;

  logic [2:0]  col_p0;
  logic [2:0]  row_p0;
  logic [1:0]  row_m1_p0;
  logic [4:0]  curpos_p0;
  logic [3:0]  tidx_p0;
  logic [3:0]  curdata_p0;
  logic        tick_p0;
  logic        blank_p0;

  logic [4:0]  curpos_p1;
  logic [3:0]  curdata_p1;
  logic [10:0] h_cnt_p1;
  logic [10:0] v_cnt_p1;
  logic        tick_p1;
  logic [7:0]  frame_cnt_p1;

  // Returns 1..4 for the tile span containing cnt, 0 for margins and gaps.
  function automatic logic [2:0] axis_idx(input logic [10:0] cnt, input int unsigned base);
    logic [2:0]  idx;
    logic [31:0] c;
    idx = '0;
    c   = {21'd0, cnt};
    for (int unsigned i = 0; i < 4; i++) begin
      if (c >= base + i * PITCH && c < base + i * PITCH + TILE) idx = 3'(i + 1);
    end
    return idx;
  endfunction

  // Tile codes 12..15 have no artwork, so they render as empty.
  function automatic logic [3:0] tile_val(input logic [3:0] v);
    return (v >= 4'd12) ? 4'd0 : v;
  endfunction

  always_comb begin
    col_p0     = axis_idx(bus.h_cnt, X0);
    row_p0     = axis_idx(bus.v_cnt, Y0);
    row_m1_p0  = row_p0[1:0] - 2'd1;
    curpos_p0  = '0;
    if (col_p0 != 3'd0 && row_p0 != 3'd0)
      curpos_p0 = 5'({row_m1_p0, 2'b00}) + {2'b00, col_p0};
    tidx_p0    = 4'(curpos_p0 - 5'd1);
    curdata_p0 = '0;
    if (curpos_p0 != 5'd0)
      curdata_p0 = tile_val(shadow[{tidx_p0, 2'b00} +: 4]);
    tick_p0    = (bus.v_cnt == 11'(V_ACTIVE)) && (bus.h_cnt == 11'd0);
    blank_p0   = (bus.v_cnt >= 11'(V_ACTIVE));
  end

  // p0 -> p1: decode results registered alongside the counters they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curpos_p1    <= '0;
      curdata_p1   <= '0;
      h_cnt_p1     <= '0;
      v_cnt_p1     <= '0;
      tick_p1      <= 1'b0;
      frame_cnt_p1 <= '0;
    end else begin
      curpos_p1  <= curpos_p0;
      curdata_p1 <= curdata_p0;
      h_cnt_p1   <= bus.h_cnt;
      v_cnt_p1   <= bus.v_cnt;
      tick_p1    <= tick_p0;
      if (tick_p0) frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
    end
  end

  // Commit handshake; shadow is only written in LATCH, which is reachable only from blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      upd_ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          upd_ack_q <= 1'b0;
          if (bus.upd_req && blank_p0) state <= LATCH;
        end
        LATCH: begin
          shadow    <= bus.board_in;
          upd_ack_q <= 1'b1;
          state     <= WAIT_DROP;
        end
        WAIT_DROP: begin
          upd_ack_q <= 1'b0;
          if (!bus.upd_req) state <= IDLE;
        end
        default: begin
          upd_ack_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.upd_ack    = upd_ack_q;
  assign bus.curpos     = curpos_p1;
  assign bus.curdata    = curdata_p1;
  assign bus.h_cnt_q    = h_cnt_p1;
  assign bus.v_cnt_q    = v_cnt_p1;
  assign bus.frame_tick = tick_p1;
  assign bus.frame_cnt  = frame_cnt_p1;

endmodule

// File: tb/tb_tile_render_sched.sv
// Scoreboard bench for tile_render_sched: directed pixel/commit/frame vectors push
// expectations; a monitor sampling after each rising edge pops and compares.
module tb_tile_render_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tile_render_sched_if bus();

  tile_render_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    bit          is_pix;
    logic [4:0]  pos;
    logic [3:0]  dat;
    logic [10:0] hq;
    logic [10:0] vq;
    logic [7:0]  fc;
    logic        tick;
    logic        ack;
  } exp_t;

  exp_t  exp_q[$];
  int    ack_due_q[$];
  string ack_name_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   acks_seen = 0;
  int   ticks_seen = 0;
  logic [7:0] exp_fc = 8'd0;
  logic prev_ack = 1'b0;
  exp_t  me;
  string mname;
  int    mdue;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.frame_tick === 1'b1) ticks_seen++;
    if (bus.upd_ack === 1'b1) begin
      check("ack_single_pulse", 32'(prev_ack), 32'd0);
      if (ack_due_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        mname = ack_name_q.pop_front();
        mdue  = ack_due_q.pop_front();
        check({mname, "_ack_cycle"}, 32'(cyc), 32'(mdue));
        acks_seen++;
      end
    end
    prev_ack = bus.upd_ack;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      me = exp_q.pop_front();
      if (me.is_pix) begin
        check({me.name, "_curpos"}, 32'(bus.curpos), 32'(me.pos));
        check({me.name, "_curdata"}, 32'(bus.curdata), 32'(me.dat));
        check({me.name, "_hv_q"}, 32'({bus.h_cnt_q, bus.v_cnt_q}), 32'({me.hq, me.vq}));
      end else begin
        check({me.name, "_upd_ack"}, 32'(bus.upd_ack), 32'(me.ack));
        check({me.name, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(me.fc));
        check({me.name, "_frame_tick"}, 32'(bus.frame_tick), 32'(me.tick));
      end
    end
  end

  task automatic drive(input int h, input int v);
    @(negedge clk);
    bus.h_cnt = 11'(h);
    bus.v_cnt = 11'(v);
    if (rst_n && h == 0 && v == 480) exp_fc++;
  endtask

  task automatic probe(input string name, input int h, input int v, input int pos, input int dat);
    exp_t e;
    drive(h, v);
    e.due = cyc + 1; e.name = name; e.is_pix = 1'b1;
    e.pos = 5'(pos); e.dat = 4'(dat); e.hq = 11'(h); e.vq = 11'(v);
    e.fc = exp_fc; e.tick = 1'b0; e.ack = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic probe_tile(input string name, input int k, input int dat);
    probe(name, 136 + (k % 4) * 96 + 4, 66 + (k / 4) * 96 + 4, k + 1, dat);
  endtask

  task automatic stat(input string name, input int h, input int v, input logic ack);
    exp_t e;
    drive(h, v);
    e.due = cyc + 1; e.name = name; e.is_pix = 1'b0;
    e.pos = '0; e.dat = '0; e.hq = 11'(h); e.vq = 11'(v);
    e.fc = exp_fc; e.tick = rst_n && (h == 0) && (v == 480); e.ack = ack;
    exp_q.push_back(e);
  endtask

  // First blank pixel with a pending request: ack must appear exactly two edges later.
  task automatic blank_commit(input string name);
    drive(5, 480);
    ack_name_q.push_back(name);
    ack_due_q.push_back(cyc + 2);
  endtask

  task automatic wait_ack(input string name, input int max_cycles);
    int start;
    int n;
    start = acks_seen;
    n = 0;
    while (acks_seen == start && n < max_cycles) begin
      drive(5, 481);
      n++;
    end
    if (acks_seen == start) check({name, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic commit(input string name, input logic [63:0] board);
    drive(5, 100);
    bus.board_in = board;
    bus.upd_req  = 1'b1;
    blank_commit(name);
    wait_ack(name, 10);
    bus.upd_req = 1'b0;
    drive(5, 482);
    drive(5, 100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus.h_cnt    = 11'd0;
    bus.v_cnt    = 11'd0;
    bus.board_in = '1;
    bus.upd_req  = 1'b0;

    // 1: reset state, then all tiles empty despite board_in = all ones
    stat("reset", 5, 100, 1'b0);
    drive(5, 100);
    rst_n = 1'b1;
    stat("post_reset", 5, 100, 1'b0);
    for (int k = 0; k < 16; k++) probe_tile("empty", k, 0);

    // 2: request in active area waits for blank; v_cnt 479 is still active
    bus.board_in = 64'h3;
    bus.upd_req  = 1'b1;
    repeat (8) drive(5, 100);
    repeat (4) drive(5, 479);
    blank_commit("t2");
    wait_ack("t2", 10);
    bus.upd_req = 1'b0;
    drive(5, 482);
    probe("t2_pix", 140, 70, 1, 3);

    // 3: decode edges
    probe("x135", 135, 70, 0, 0);
    probe("x136y66", 136, 66, 1, 3);
    probe("x215y145", 215, 145, 1, 3);
    probe("x216", 216, 70, 0, 0);
    probe("x232", 232, 70, 2, 0);
    probe("x503y433", 503, 433, 16, 0);
    probe("x504", 504, 433, 0, 0);
    probe("y65", 140, 65, 0, 0);
    probe("y146", 140, 146, 0, 0);
    probe("x424y354", 424, 354, 16, 0);

    // 4: request held across three frames commits once
    drive(5, 100);
    bus.board_in = 64'h5;
    bus.upd_req  = 1'b1;
    blank_commit("t4a");
    wait_ack("t4a", 10);
    bus.board_in = 64'h7;
    for (int f = 0; f < 3; f++) begin
      repeat (3) drive(5, 100);
      stat("held_tick", 0, 480, 1'b0);
      repeat (3) drive(5, 490);
    end
    probe_tile("held_keep", 0, 5);
    bus.upd_req = 1'b0;
    drive(5, 100);
    drive(5, 100);
    commit("t4b", 64'h9);
    probe_tile("recommit", 0, 9);

    // 5: codes 12..15 render empty, 11 renders as is
    commit("t5", 64'hFCBD);
    probe_tile("val13", 0, 0);
    probe_tile("val11", 1, 11);
    probe_tile("val12", 2, 0);
    probe_tile("val15", 3, 0);

    // 6: reset during WAIT_DROP while ack is high
    drive(5, 100);
    bus.board_in = 64'h6;
    bus.upd_req  = 1'b1;
    blank_commit("t6");
    wait_ack("t6", 10);
    rst_n = 1'b0;
    #1;
    check("rst_ack_drop", 32'(bus.upd_ack), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    exp_fc = 8'd0;
    stat("in_reset", 5, 100, 1'b0);
    bus.upd_req = 1'b0;
    drive(5, 100);
    rst_n = 1'b1;
    probe_tile("rst_shadow", 0, 0);

    // 256 frames wrap the counter
    drive(5, 100);
    t0 = ticks_seen;
    for (int i = 0; i < 256; i++) begin
      if (i == 0) stat("fc_1", 0, 480, 1'b0);
      else if (i == 254) stat("fc_255", 0, 480, 1'b0);
      else drive(0, 480);
      drive(5, 481);
    end
    stat("fc_wrap", 5, 100, 1'b0);
    drive(5, 100);
    drive(5, 100);
    check("tick_count", 32'(ticks_seen - t0), 32'd256);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("ack_queue_drained", 32'(ack_due_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
